timer_apb_slave: RTL and testbench

APB3 completer (slave) for the 8-bit timer subsystem. It holds the timer register file, runs an 8-bit up/down counter with a prescaler, and raises an interrupt on overflow or underflow. It sits on the same 8-bit-address, 8-bit-data APB bus driven by the CPU bus-functional model, and answers its write/read transfers with `pready`/`pslverr`.

---
 rtl/timer_apb_pkg.sv | 25 ++
 rtl/timer_apb_slave_if.sv | 21 ++
 rtl/timer_counter_core.sv | 65 ++++++
 rtl/timer_apb_slave.sv | 116 +++++++++++
 tb/tb_timer_apb_slave.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/timer_apb_pkg.sv
// Shared constants for the APB timer block: register map, bit positions and the APB FSM states.
package timer_apb_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TIER = 8'h03;
    localparam logic [7:0] ADDR_TCNT = 8'h04;

    localparam int unsigned TCR_LOAD = 7;
    localparam int unsigned TCR_DIR  = 5;
    localparam int unsigned TCR_EN   = 4;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    localparam int unsigned TIER_OVF_EN = 0;
    localparam int unsigned TIER_UDF_EN = 1;

    // load is a one-shot command, so only dir, en and cks are kept in TCR
    localparam logic [7:0] TCR_STORE_MASK = 8'h37;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

endpackage

// File: rtl/timer_apb_slave_if.sv
// APB3 signal bundle between the CPU bus model (master) and the timer completer (slave).
interface timer_apb_slave_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_counter_core.sv
// Prescaler plus 8-bit up/down counter; sets overflow/underflow flags on the wrapping tick.
module timer_counter_core (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       en,
    input  logic       dir,
    input  logic [2:0] cks,
    input  logic       load_pulse,
    input  logic [7:0] load_val,
    input  logic       clr_ovf,
    input  logic       clr_udf,
    output logic [7:0] tcnt,
    output logic       ovf,
    output logic       udf
);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       ovf_q, ovf_d, udf_q, udf_d;
    logic [7:0] mask;
    logic       tick, wrap_up, wrap_dn;

    always_comb begin
        // cks == 0 gives an empty mask, so every enabled cycle ticks
        mask      = (8'd1 << cks) - 8'd1;
        tick      = en && ((div_cnt_q & mask) == mask);
        div_cnt_d = (!en || load_pulse) ? 8'd0 : div_cnt_q + 8'd1;
        tcnt_d    = tcnt_q;
        wrap_up   = 1'b0;
        wrap_dn   = 1'b0;
        if (load_pulse) begin
            tcnt_d = load_val;
        end else if (tick) begin
            if (dir) begin
                tcnt_d  = tcnt_q - 8'd1;
                wrap_dn = (tcnt_q == 8'h00);
            end else begin
                tcnt_d  = tcnt_q + 8'd1;
                wrap_up = (tcnt_q == 8'hFF);
            end
        end
        // a set on the same edge as a clear wins
        ovf_d = wrap_up | (ovf_q & ~clr_ovf);
        udf_d = wrap_dn | (udf_q & ~clr_udf);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            div_cnt_q <= 8'd0;
            tcnt_q    <= 8'd0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tcnt_q    <= tcnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign tcnt = tcnt_q;
    assign ovf  = ovf_q;
    assign udf  = udf_q;

endmodule

// File: rtl/timer_apb_slave.sv
// APB3 completer for the 8-bit timer: transfer FSM, address decode and the TDR/TCR/TIER registers.
module timer_apb_slave
    import timer_apb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               pclk,
    input  logic               preset_n,
    timer_apb_slave_if.slave   apb,
    output logic               irq
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    apb_state_t state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [7:0] tdr_q, tcr_q;
    logic [1:0] tier_q;
    logic       addr_err, wr_commit, load_pulse, clr_ovf, clr_udf;
    logic [7:0] tcnt;
    logic       ovf, udf;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) state_d = SETUP;
            end
            SETUP: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (apb.penable) begin
                    state_d = ACCESS;
                    wcnt_d  = 3'd0;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                    wcnt_d  = 3'd0;
                end else if (wcnt_q == WS) begin
                    state_d = apb.penable ? IDLE : SETUP;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign apb.pready  = (state_q == ACCESS) && (wcnt_q == WS);
    assign addr_err    = (apb.paddr > ADDR_TCNT) || (apb.pwrite && apb.paddr == ADDR_TCNT);
    assign apb.pslverr = apb.pready && addr_err;
    assign wr_commit   = apb.pready && apb.psel && apb.penable && apb.pwrite && !addr_err;
    assign load_pulse  = wr_commit && (apb.paddr == ADDR_TCR) && apb.pwdata[TCR_LOAD];
    assign clr_ovf     = wr_commit && (apb.paddr == ADDR_TSR) && apb.pwdata[TSR_OVF];
    assign clr_udf     = wr_commit && (apb.paddr == ADDR_TSR) && apb.pwdata[TSR_UDF];

    always_comb begin
        apb.prdata = 8'h00;
        if (state_q == ACCESS && !addr_err) begin
            case (apb.paddr)
                ADDR_TDR:  apb.prdata = tdr_q;
                ADDR_TCR:  apb.prdata = tcr_q;
                ADDR_TSR:  apb.prdata = {6'd0, udf, ovf};
                ADDR_TIER: apb.prdata = {6'd0, tier_q};
                ADDR_TCNT: apb.prdata = tcnt;
                default:   apb.prdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tdr_q  <= 8'h00;
            tcr_q  <= 8'h00;
            tier_q <= 2'b00;
        end else if (wr_commit) begin
            case (apb.paddr)
                ADDR_TDR:  tdr_q  <= apb.pwdata;
                ADDR_TCR:  tcr_q  <= apb.pwdata & TCR_STORE_MASK;
                ADDR_TIER: tier_q <= apb.pwdata[1:0];
                default:   ;
            endcase
        end
    end

    timer_counter_core u_core (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .en         (tcr_q[TCR_EN]),
        .dir        (tcr_q[TCR_DIR]),
        .cks        (tcr_q[2:0]),
        .load_pulse (load_pulse),
        .load_val   (tdr_q),
        .clr_ovf    (clr_ovf),
        .clr_udf    (clr_udf),
        .tcnt       (tcnt),
        .ovf        (ovf),
        .udf        (udf)
    );

    assign irq = (ovf & tier_q[TIER_OVF_EN]) | (udf & tier_q[TIER_UDF_EN]);

endmodule

// File: tb/tb_timer_apb_slave.sv
// Directed bench for timer_apb_slave: a bus driver queues expected responses, a monitor checks them.
module tb_timer_apb_slave;

    localparam int unsigned WS = 1;

    typedef struct {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic pclk;
    logic preset_n;
    logic irq;
    timer_apb_slave_if bus ();

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_cycles = 0;

    timer_apb_slave #(.WAIT_STATES(WS)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .apb      (bus),
        .irq      (irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every completing cycle pops one expectation. penable is high for one cycle while
    // the FSM sits in SETUP, then WS+1 cycles in ACCESS.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!preset_n || !bus.psel) begin
                acc_cycles = 0;
            end else if (bus.penable) begin
                acc_cycles++;
                if (bus.pready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_xfer: addr %h completed with no expectation",
                                 bus.paddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("pslverr@%h", e.addr), {7'd0, bus.pslverr}, {7'd0, e.err});
                        if (!e.is_write) chk($sformatf("prdata@%h", e.addr), bus.prdata, e.rdata);
                        chk($sformatf("latency@%h", e.addr), 8'(acc_cycles), 8'(WS + 2));
                    end
                    acc_cycles = 0;
                end
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   done;
        int   n;
        e.is_write = wr;
        e.addr     = addr;
        e.rdata    = exp_rd;
        e.err      = exp_err;
        exp_q.push_back(e);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        done = 1'b0;
        n    = 0;
        while (!done && n < 32) begin
            if (bus.pready === 1'b1) done = 1'b1;
            @(posedge pclk); #1;
            n++;
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout: addr %h got no pready, want pready within 32 cycles",
                     addr);
            e = exp_q.pop_back();
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic err = 1'b0);
        apb_xfer(1'b1, addr, data, 8'h00, err);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input logic err = 1'b0);
        apb_xfer(1'b0, addr, 8'h00, exp, err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 8'h00;
        bus.pwdata  = 8'h00;
        preset_n    = 1'b0;
        idle(3);
        preset_n = 1'b1;
        idle(1);
        chk("rst_prdata",  bus.prdata, 8'h00);
        chk("rst_pready",  {7'd0, bus.pready}, 8'h00);
        chk("rst_pslverr", {7'd0, bus.pslverr}, 8'h00);
        chk("rst_irq",     {7'd0, irq}, 8'h00);

        for (int a = 0; a <= 4; a++) rd(8'(a), 8'h00);

        // Up count from 0xFD: the TCNT read completes WS+2 ticks after the TCR commit edge
        wr(8'h00, 8'hFD);
        wr(8'h03, 8'h01);
        wr(8'h01, 8'h90);
        rd(8'h04, 8'(8'hFD + WS + 2));
        rd(8'h02, 8'h01);
        chk("irq_ovf_set", {7'd0, irq}, 8'h01);
        wr(8'h02, 8'h01);
        chk("irq_ovf_clr", {7'd0, irq}, 8'h00);
        rd(8'h02, 8'h00);
        wr(8'h01, 8'h00);

        // Down count from 0x01 through the underflow, interrupts masked
        wr(8'h03, 8'h00);
        wr(8'h00, 8'h01);
        wr(8'h01, 8'hA0);
        rd(8'h04, 8'h01);
        wr(8'h01, 8'h30);
        rd(8'h04, 8'(8'h01 - WS - 2));
        wr(8'h01, 8'h00);
        rd(8'h02, 8'h02);
        chk("irq_masked", {7'd0, irq}, 8'h00);
        rd(8'h03, 8'h00);
        wr(8'h02, 8'h03);
        rd(8'h02, 8'h00);

        // Prescaler cks=3: stop write is timed so its commit lands 80 edges after start
        wr(8'h00, 8'h00);
        wr(8'h01, 8'h80);
        wr(8'h01, 8'h13);
        idle(80 - (WS + 3));
        wr(8'h01, 8'h03);
        rd(8'h04, 8'h0A);
        rd(8'h01, 8'h03);

        // Error responses
        wr(8'h07, 8'h55, 1'b1);
        wr(8'h04, 8'h55, 1'b1);
        rd(8'h07, 8'h00, 1'b1);
        rd(8'h04, 8'h0A);
        rd(8'h00, 8'h00);

        // Reset during the ACCESS phase of a TDR write
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 8'h00;
        bus.pwdata  = 8'hAA;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        preset_n = 1'b0;
        #1;
        chk("abort_pready", {7'd0, bus.pready}, 8'h00);
        chk("abort_prdata", bus.prdata, 8'h00);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        idle(1);
        preset_n = 1'b1;
        idle(1);
        rd(8'h00, 8'h00);
        rd(8'h04, 8'h00);
        rd(8'h02, 8'h00);

        // TSR clear committing on the very edge the overflow happens
        wr(8'h03, 8'h01);
        wr(8'h00, 8'(256 - WS - 3));
        wr(8'h01, 8'h80);
        wr(8'h01, 8'h10);
        wr(8'h02, 8'h01);
        chk("irq_set_wins", {7'd0, irq}, 8'h01);
        rd(8'h02, 8'h01);
        wr(8'h01, 8'h00);

        idle(3);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
